// File: rtl/munoc_axi4_slave_access_scheduler_if.sv
// Valid/ready handshake bundle between the MUNOC network interface, the scheduler and the AXI4 slave.
// master = scheduler view, slave = surrounding NI/slave environment view.
interface munoc_axi4_slave_access_scheduler_if;
  logic ni_awvalid;
  logic ni_awready;
  logic sx4awvalid;
  logic sx4awready;
  logic ni_arvalid;
  logic ni_arready;
  logic sx4arvalid;
  logic sx4arready;
  logic ni_wvalid;
  logic ni_wlast;
  logic ni_wready;
  logic sx4wvalid;
  logic sx4wready;
  logic sx4bvalid;
  logic sx4bready;
  logic sx4rvalid;
  logic sx4rready;
  logic sx4rlast;

  modport master (
    input  ni_awvalid, sx4awready, ni_arvalid, sx4arready,
    input  ni_wvalid, ni_wlast, sx4wready,
    input  sx4bvalid, sx4bready, sx4rvalid, sx4rready, sx4rlast,
    output ni_awready, sx4awvalid, ni_arready, sx4arvalid, ni_wready, sx4wvalid
  );

  modport slave (
    output ni_awvalid, sx4awready, ni_arvalid, sx4arready,
    output ni_wvalid, ni_wlast, sx4wready,
    output sx4bvalid, sx4bready, sx4rvalid, sx4rready, sx4rlast,
    input  ni_awready, sx4awvalid, ni_arready, sx4arvalid, ni_wready, sx4wvalid
  );
endinterface

// File: rtl/munoc_axi4_slave_access_scheduler.sv
// Gates AW/AR/W valid-ready between NI and slave: outstanding limits, one-address-per-cycle RR grant,
// W-after-AW ordering and comm_disable drain/halt. Zero added latency; backpressure passes straight through.
module munoc_axi4_slave_access_scheduler #(
  parameter int MAX_OUTSTANDING_WR = 4,
  parameter int MAX_OUTSTANDING_RD = 4,
  parameter int MAX_AW_AHEAD       = 2,
  localparam int WR_W = $clog2(MAX_OUTSTANDING_WR + 1),
  localparam int RD_W = $clog2(MAX_OUTSTANDING_RD + 1),
  localparam int AH_W = $clog2(MAX_AW_AHEAD + 1)
) (
  input  logic                                       clk,
  input  logic                                       rstp,
  input  logic                                       comm_disable,
  munoc_axi4_slave_access_scheduler_if.master        bus,
  output logic [WR_W-1:0]                            wr_outstanding,
  output logic [RD_W-1:0]                            rd_outstanding,
  output logic                                       halted
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  localparam logic [WR_W-1:0] WR_MAX = WR_W'(MAX_OUTSTANDING_WR);
  localparam logic [RD_W-1:0] RD_MAX = RD_W'(MAX_OUTSTANDING_RD);
  localparam logic [AH_W-1:0] AH_MAX = AH_W'(MAX_AW_AHEAD);

  state_t          r_state, w_state_nxt;
  logic [WR_W-1:0] r_wr_cnt;
  logic [RD_W-1:0] r_rd_cnt;
  logic [AH_W-1:0] r_aw_ahead;
  logic            r_prio, r_lock_aw, r_lock_ar, r_w_open;

  logic w_aw_elig, w_ar_elig, w_gnt_aw, w_gnt_ar, w_w_pass;
  logic w_aw_hs, w_ar_hs, w_w_hs, w_wlast_hs, w_b_hs, w_rlast_hs, w_idle;

  assign w_aw_elig = bus.ni_awvalid & (r_state == ST_RUN) & (r_wr_cnt < WR_MAX) & (r_aw_ahead < AH_MAX);
  assign w_ar_elig = bus.ni_arvalid & (r_state == ST_RUN) & (r_rd_cnt < RD_MAX);

  // A presented-but-unaccepted address keeps its grant regardless of limits or drain.
  always_comb begin
    w_gnt_aw = 1'b0;
    w_gnt_ar = 1'b0;
    if (r_lock_aw) begin
      w_gnt_aw = 1'b1;
    end else if (r_lock_ar) begin
      w_gnt_ar = 1'b1;
    end else if (w_aw_elig && w_ar_elig) begin
      w_gnt_aw = ~r_prio;
      w_gnt_ar = r_prio;
    end else begin
      w_gnt_aw = w_aw_elig;
      w_gnt_ar = w_ar_elig;
    end
    if (rstp) begin
      w_gnt_aw = 1'b0;
      w_gnt_ar = 1'b0;
    end
  end

  assign w_w_pass = (r_aw_ahead != '0) | r_w_open;

  assign bus.sx4awvalid = bus.ni_awvalid & w_gnt_aw;
  assign bus.ni_awready = bus.sx4awready & w_gnt_aw;
  assign bus.sx4arvalid = bus.ni_arvalid & w_gnt_ar;
  assign bus.ni_arready = bus.sx4arready & w_gnt_ar;
  assign bus.sx4wvalid  = bus.ni_wvalid & w_w_pass;
  assign bus.ni_wready  = bus.sx4wready & w_w_pass;

  assign w_aw_hs    = bus.sx4awvalid & bus.sx4awready;
  assign w_ar_hs    = bus.sx4arvalid & bus.sx4arready;
  assign w_w_hs     = bus.sx4wvalid & bus.sx4wready;
  assign w_wlast_hs = w_w_hs & bus.ni_wlast;
  assign w_b_hs     = bus.sx4bvalid & bus.sx4bready;
  assign w_rlast_hs = bus.sx4rvalid & bus.sx4rready & bus.sx4rlast;

  assign w_idle = (r_wr_cnt == '0) & (r_rd_cnt == '0) & (r_aw_ahead == '0) &
                  ~r_w_open & ~r_lock_aw & ~r_lock_ar;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (comm_disable) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!comm_disable) w_state_nxt = ST_RUN;
                else if (w_idle) w_state_nxt = ST_HALT;
      ST_HALT:  if (!comm_disable) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      r_state    <= ST_RUN;
      r_prio     <= 1'b0;
      r_lock_aw  <= 1'b0;
      r_lock_ar  <= 1'b0;
      r_w_open   <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_aw_ahead <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_aw <= bus.sx4awvalid & ~bus.sx4awready;
      r_lock_ar <= bus.sx4arvalid & ~bus.sx4arready;
      if (w_aw_hs || w_ar_hs) r_prio <= ~r_prio;
      if (w_w_hs) r_w_open <= ~bus.ni_wlast;

      // Counters saturate rather than wrap on an illegal extra increment/decrement.
      if (w_aw_hs && !w_b_hs && r_wr_cnt != WR_MAX) r_wr_cnt <= r_wr_cnt + WR_W'(1);
      else if (!w_aw_hs && w_b_hs && r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - WR_W'(1);

      if (w_ar_hs && !w_rlast_hs && r_rd_cnt != RD_MAX) r_rd_cnt <= r_rd_cnt + RD_W'(1);
      else if (!w_ar_hs && w_rlast_hs && r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - RD_W'(1);

      if (w_aw_hs && !w_wlast_hs && r_aw_ahead != AH_MAX) r_aw_ahead <= r_aw_ahead + AH_W'(1);
      else if (!w_aw_hs && w_wlast_hs && r_aw_ahead != '0) r_aw_ahead <= r_aw_ahead - AH_W'(1);
    end
  end

  assign wr_outstanding = r_wr_cnt;
  assign rd_outstanding = r_rd_cnt;
  assign halted         = (r_state == ST_HALT);

endmodule

// File: tb/tb_munoc_axi4_slave_access_scheduler.sv
// Bench for the access scheduler: reset-state vector table, directed multi-cycle sequences,
// then randomized traffic compared every cycle against a counting reference model.
module tb_munoc_axi4_slave_access_scheduler;
  localparam int MWR = 4;
  localparam int MRD = 4;
  localparam int MAH = 2;

  logic       clk;
  logic       rstp;
  logic       comm_disable;
  logic [2:0] wr_outstanding;
  logic [2:0] rd_outstanding;
  logic       halted;

  munoc_axi4_slave_access_scheduler_if bus();

  munoc_axi4_slave_access_scheduler #(
    .MAX_OUTSTANDING_WR(MWR),
    .MAX_OUTSTANDING_RD(MRD),
    .MAX_AW_AHEAD(MAH)
  ) u_dut (
    .clk(clk),
    .rstp(rstp),
    .comm_disable(comm_disable),
    .bus(bus),
    .wr_outstanding(wr_outstanding),
    .rd_outstanding(rd_outstanding),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: open-transaction counts, burst-in-progress flag, preferred channel,
  // mode (0 run, 1 drain, 2 halt) and the channel whose address is stalled (-1 none).
  int  m_wr, m_rd, m_ah, m_mode, m_lock, m_g;
  bit  m_wopen, m_prio, m_wpass, last_awhs;
  logic [12:0] exp_vec;

  function automatic int clamp(input int v, input int mx);
    return (v < 0) ? 0 : ((v > mx) ? mx : v);
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_ah = 0; m_mode = 0; m_lock = -1;
    m_wopen = 0; m_prio = 0; m_g = -1; last_awhs = 0;
  endtask

  task automatic model_eval();
    bit aw_el, ar_el;
    aw_el = bus.ni_awvalid && m_mode == 0 && m_wr < MWR && m_ah < MAH;
    ar_el = bus.ni_arvalid && m_mode == 0 && m_rd < MRD;
    if (rstp)               m_g = -1;
    else if (m_lock >= 0)   m_g = m_lock;
    else if (aw_el && ar_el) m_g = int'(m_prio);
    else if (aw_el)         m_g = 0;
    else if (ar_el)         m_g = 1;
    else                    m_g = -1;
    m_wpass = (m_ah > 0) || m_wopen;
    exp_vec = {bus.ni_awvalid && m_g == 0, bus.sx4awready && m_g == 0,
               bus.ni_arvalid && m_g == 1, bus.sx4arready && m_g == 1,
               bus.ni_wvalid && m_wpass, bus.sx4wready && m_wpass,
               m_mode == 2, 3'(m_wr), 3'(m_rd)};
  endtask

  task automatic model_update();
    int awhs, arhs, wlhs, bhs, rhs;
    bit idle, whs;
    if (rstp) begin
      model_reset();
    end else begin
      awhs = (m_g == 0 && bus.ni_awvalid && bus.sx4awready) ? 1 : 0;
      arhs = (m_g == 1 && bus.ni_arvalid && bus.sx4arready) ? 1 : 0;
      whs  = m_wpass && bus.ni_wvalid && bus.sx4wready;
      wlhs = (whs && bus.ni_wlast) ? 1 : 0;
      bhs  = (bus.sx4bvalid && bus.sx4bready) ? 1 : 0;
      rhs  = (bus.sx4rvalid && bus.sx4rready && bus.sx4rlast) ? 1 : 0;
      idle = m_wr == 0 && m_rd == 0 && m_ah == 0 && !m_wopen && m_lock < 0;
      case (m_mode)
        0: if (comm_disable) m_mode = 1;
        1: if (!comm_disable) m_mode = 0; else if (idle) m_mode = 2;
        default: if (!comm_disable) m_mode = 0;
      endcase
      if (m_g == 0 && bus.ni_awvalid && !bus.sx4awready)      m_lock = 0;
      else if (m_g == 1 && bus.ni_arvalid && !bus.sx4arready) m_lock = 1;
      else                                                    m_lock = -1;
      if (awhs + arhs > 0) m_prio = !m_prio;
      if (whs) m_wopen = !bus.ni_wlast;
      m_wr = clamp(m_wr + awhs - bhs, MWR);
      m_rd = clamp(m_rd + arhs - rhs, MRD);
      m_ah = clamp(m_ah + awhs - wlhs, MAH);
      last_awhs = (awhs == 1);
    end
  endtask

  function automatic logic [12:0] act_vec();
    return {bus.sx4awvalid, bus.ni_awready, bus.sx4arvalid, bus.ni_arready,
            bus.sx4wvalid, bus.ni_wready, halted, wr_outstanding, rd_outstanding};
  endfunction

  task automatic half();
    @(negedge clk);
    if (rstp) model_reset();
    model_eval();
    chk("model", 32'(act_vec()), 32'(exp_vec));
  endtask

  task automatic edge_();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    half();
    edge_();
  endtask

  task automatic idle_in();
    bus.ni_awvalid = 0; bus.ni_arvalid = 0; bus.ni_wvalid = 0; bus.ni_wlast = 0;
    bus.sx4awready = 0; bus.sx4arready = 0; bus.sx4wready = 0;
    bus.sx4bvalid = 0; bus.sx4bready = 0; bus.sx4rvalid = 0; bus.sx4rready = 0; bus.sx4rlast = 0;
  endtask

  typedef struct {
    string      name;
    logic [7:0] in;   // {awv, arv, wv, wlast, awrdy, arrdy, wrdy, comm_disable}
    logic [5:0] out;  // {sx4awvalid, ni_awready, sx4arvalid, ni_arready, sx4wvalid, ni_wready}
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"aw_only",      8'b1000_1000, 6'b11_00_00};
    vecs[1] = '{"ar_only",      8'b0100_0100, 6'b00_11_00};
    vecs[2] = '{"both_prio_aw", 8'b1100_1100, 6'b11_00_00};
    vecs[3] = '{"aw_stall",     8'b1000_0000, 6'b10_00_00};
    vecs[4] = '{"w_gated",      8'b0011_0010, 6'b00_00_00};
    vecs[5] = '{"cd_same_cyc",  8'b1100_1101, 6'b11_00_00};
    vecs[6] = '{"ready_no_vld", 8'b0000_1110, 6'b00_00_00};
    vecs[7] = '{"all_on",       8'b1111_1111, 6'b11_00_00};

    rstp = 1; comm_disable = 0; idle_in(); model_reset();
    repeat (2) @(posedge clk);
    #1;
    bus.ni_awvalid = 1; bus.ni_arvalid = 1; bus.sx4awready = 1; bus.sx4arready = 1;
    bus.ni_wvalid = 1; bus.sx4wready = 1;
    @(negedge clk);
    chk("rst_gated", 32'({bus.sx4awvalid, bus.ni_awready, bus.sx4arvalid, bus.ni_arready,
                          bus.sx4wvalid, bus.ni_wready}), 32'd0);
    chk("rst_status", 32'({halted, wr_outstanding, rd_outstanding}), 32'd0);
    idle_in();
    @(posedge clk);
    #1 rstp = 0;

    // Combinational gating from the reset state; inputs go idle before each edge.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      {bus.ni_awvalid, bus.ni_arvalid, bus.ni_wvalid, bus.ni_wlast,
       bus.sx4awready, bus.sx4arready, bus.sx4wready, comm_disable} = vecs[i].in;
      #1;
      chk(vecs[i].name, 32'({bus.sx4awvalid, bus.ni_awready, bus.sx4arvalid, bus.ni_arready,
                             bus.sx4wvalid, bus.ni_wready}), 32'(vecs[i].out));
      idle_in();
      comm_disable = 0;
    end
    @(posedge clk);
    #1;

    // Back-to-back AW/AR alternate until both limits are reached.
    bus.ni_awvalid = 1; bus.ni_arvalid = 1; bus.sx4awready = 1; bus.sx4arready = 1;
    bus.ni_wvalid = 1; bus.ni_wlast = 1; bus.sx4wready = 1;
    for (int k = 0; k < 8; k++) begin
      half();
      chk("b2b_aw", 32'(bus.sx4awvalid), 32'(k % 2 == 0));
      chk("b2b_ar", 32'(bus.sx4arvalid), 32'(k % 2 == 1));
      edge_();
    end
    half();
    chk("b2b_wr_full", 32'(wr_outstanding), 32'd4);
    chk("b2b_rd_full", 32'(rd_outstanding), 32'd4);
    chk("b2b_gated", 32'({bus.sx4awvalid, bus.sx4arvalid}), 32'd0);
    edge_();
    idle_in();
    bus.sx4bvalid = 1; bus.sx4bready = 1; bus.sx4rvalid = 1; bus.sx4rready = 1; bus.sx4rlast = 1;
    repeat (4) cyc();
    idle_in();
    half();
    chk("b2b_closed", 32'({wr_outstanding, rd_outstanding}), 32'd0);
    edge_();

    // Read limit: the slot freed by an R-last is usable only in the following cycle.
    bus.ni_arvalid = 1; bus.sx4arready = 1;
    repeat (4) cyc();
    half(); chk("rd_limit_block", 32'(bus.sx4arvalid), 32'd0); edge_();
    bus.sx4rvalid = 1; bus.sx4rready = 1; bus.sx4rlast = 1;
    half(); chk("rd_free_same_cyc", 32'(bus.sx4arvalid), 32'd0); edge_();
    bus.sx4rvalid = 0;
    half();
    chk("rd_free_next_cyc", 32'(bus.sx4arvalid), 32'd1);
    chk("rd_cnt_after_r", 32'(rd_outstanding), 32'd3);
    edge_();
    bus.ni_arvalid = 0; bus.sx4rvalid = 1;
    repeat (4) cyc();
    idle_in();

    // W burst presented before its AW.
    bus.ni_wvalid = 1; bus.sx4wready = 1;
    repeat (2) begin half(); chk("w_before_aw", 32'(bus.sx4wvalid), 32'd0); edge_(); end
    bus.ni_awvalid = 1; bus.sx4awready = 1;
    half(); chk("w_aw_cycle", 32'({bus.sx4awvalid, bus.sx4wvalid}), 32'b10); edge_();
    bus.ni_awvalid = 0;
    for (int b = 0; b < 4; b++) begin
      bus.ni_wlast = (b == 3);
      half(); chk("w_beat", 32'(bus.sx4wvalid), 32'd1); edge_();
    end
    bus.ni_wlast = 0;
    half(); chk("w_after_burst", 32'(bus.sx4wvalid), 32'd0); edge_();
    idle_in();
    bus.sx4bvalid = 1; bus.sx4bready = 1;
    cyc();
    idle_in();

    // Stalled AW keeps valid through comm_disable; nothing new issues once it completes.
    bus.ni_awvalid = 1;
    half(); chk("lock_first", 32'(bus.sx4awvalid), 32'd1); edge_();
    comm_disable = 1;
    half(); chk("lock_cd", 32'(bus.sx4awvalid), 32'd1); edge_();
    half(); chk("lock_drain", 32'({bus.sx4awvalid, halted}), 32'b10); edge_();
    bus.sx4awready = 1;
    half(); chk("lock_hs", 32'(bus.ni_awready), 32'd1); edge_();
    bus.ni_arvalid = 1; bus.sx4arready = 1;
    half(); chk("drain_no_addr", 32'({bus.sx4awvalid, bus.sx4arvalid}), 32'd0); edge_();
    idle_in();
    bus.ni_wvalid = 1; bus.ni_wlast = 1; bus.sx4wready = 1;
    half(); chk("drain_w_pass", 32'(bus.sx4wvalid), 32'd1); edge_();
    idle_in();
    bus.sx4bvalid = 1; bus.sx4bready = 1;
    cyc();
    idle_in();
    half(); chk("drain_not_yet", 32'(halted), 32'd0); edge_();
    half(); chk("drain_halted", 32'(halted), 32'd1); edge_();
    comm_disable = 0;
    cyc();

    // Halt after 2 writes and 1 read complete; then resume.
    bus.ni_awvalid = 1; bus.sx4awready = 1;
    cyc();
    bus.ni_wvalid = 1; bus.ni_wlast = 1; bus.sx4wready = 1;
    cyc();
    bus.ni_awvalid = 0; bus.ni_arvalid = 1; bus.sx4arready = 1;
    cyc();
    idle_in();
    half(); chk("h_open", 32'({wr_outstanding, rd_outstanding}), 32'({3'd2, 3'd1})); edge_();
    comm_disable = 1;
    cyc();
    bus.sx4bvalid = 1; bus.sx4bready = 1;
    repeat (2) cyc();
    idle_in();
    bus.sx4rvalid = 1; bus.sx4rready = 1; bus.sx4rlast = 1;
    cyc();
    idle_in();
    half(); chk("h_one_cycle_low", 32'(halted), 32'd0); edge_();
    half(); chk("h_high", 32'(halted), 32'd1); edge_();
    comm_disable = 0;
    half(); chk("h_still_high", 32'(halted), 32'd1); edge_();
    bus.ni_arvalid = 1; bus.sx4arready = 1;
    half(); chk("h_resume", 32'({halted, bus.sx4arvalid}), 32'b01); edge_();
    idle_in();
    bus.sx4rvalid = 1; bus.sx4rready = 1; bus.sx4rlast = 1;
    cyc();
    idle_in();

    // Reset with 3 writes open.
    bus.ni_awvalid = 1; bus.sx4awready = 1; bus.ni_wvalid = 1; bus.ni_wlast = 1; bus.sx4wready = 1;
    repeat (3) cyc();
    half(); chk("r_three_open", 32'(wr_outstanding), 32'd3); edge_();
    bus.ni_awvalid = 0; bus.ni_wvalid = 0;
    rstp = 1;
    bus.ni_awvalid = 1; bus.ni_arvalid = 1; bus.sx4arready = 1;
    half(); chk("r_during", 32'({bus.sx4awvalid, bus.sx4arvalid, wr_outstanding}), 32'd0); edge_();
    rstp = 0;
    half();
    chk("r_after_cnt", 32'({halted, wr_outstanding, rd_outstanding}), 32'd0);
    chk("r_after_prio", 32'({bus.sx4awvalid, bus.sx4arvalid}), 32'b10);
    edge_();
    idle_in();

    // Randomized traffic against the model; address valids stay up until accepted.
    for (int i = 0; i < 3000; i++) begin
      bus.ni_awvalid = (bus.ni_awvalid && !last_awhs) ? 1'b1 : ($urandom_range(0, 2) == 0);
      bus.ni_arvalid = (bus.ni_arvalid && !bus.ni_arready) ? 1'b1 : ($urandom_range(0, 2) == 0);
      bus.sx4awready = ($urandom_range(0, 3) != 0);
      bus.sx4arready = ($urandom_range(0, 3) != 0);
      bus.ni_wvalid  = $urandom_range(0, 1);
      bus.ni_wlast   = ($urandom_range(0, 2) == 0);
      bus.sx4wready  = ($urandom_range(0, 3) != 0);
      bus.sx4bvalid  = ($urandom_range(0, 2) == 0);
      bus.sx4bready  = $urandom_range(0, 1);
      bus.sx4rvalid  = ($urandom_range(0, 2) == 0);
      bus.sx4rready  = $urandom_range(0, 1);
      bus.sx4rlast   = $urandom_range(0, 1);
      if ($urandom_range(0, 63) == 0) comm_disable = !comm_disable;
      rstp = ($urandom_range(0, 499) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
